// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the load/store stage: request/writeback
// structs, funct3 encodings and the stage-1 pipeline record.
package mem_stage_pkg;

    localparam int cXLEN     = 32;
    localparam int cRamDepth = 1024;

    typedef struct packed {
        logic             read;
        logic             write;
        logic [cXLEN-1:0] addr;
        logic [cXLEN-1:0] data;
        logic [2:0]       opType;
        logic [4:0]       rdAddr;
    } tMemOp;

    typedef struct packed {
        logic             dv;
        logic [4:0]       addr;
        logic [cXLEN-1:0] data;
    } tRegOp;

    localparam tRegOp cRegOp = '{dv: 1'b0, addr: 5'd0, data: '0};

    localparam logic [2:0] cLb  = 3'b000;
    localparam logic [2:0] cLh  = 3'b001;
    localparam logic [2:0] cLw  = 3'b010;
    localparam logic [2:0] cLbu = 3'b100;
    localparam logic [2:0] cLhu = 3'b101;
    localparam logic [2:0] cSb  = 3'b000;
    localparam logic [2:0] cSh  = 3'b001;
    localparam logic [2:0] cSw  = 3'b010;

    // Everything stage 2 needs to shape the RAM word into a writeback.
    typedef struct packed {
        logic       mem;     // a memory request occupied this slot
        logic       ld;      // legal load that writes back (rd != 0)
        logic       err;
        logic [2:0] op;
        logic [1:0] lane;
        logic [4:0] rd;
        tRegOp      reg_op;
    } tMemPipe;

    function automatic logic ld_legal(input logic [2:0] op, input logic [1:0] lane);
        case (op)
            cLb, cLbu: ld_legal = 1'b1;
            cLh, cLhu: ld_legal = ~lane[0];
            cLw:       ld_legal = (lane == 2'b00);
            default:   ld_legal = 1'b0;
        endcase
    endfunction

    function automatic logic st_legal(input logic [2:0] op, input logic [1:0] lane);
        case (op)
            cSb:     st_legal = 1'b1;
            cSh:     st_legal = ~lane[0];
            cSw:     st_legal = (lane == 2'b00);
            default: st_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_data_ram.sv
// Single-port synchronous data RAM, 32-bit words with byte enables,
// one-cycle read latency, write-first on a same-address write.
module data_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    // NOTE: storage has no reset; contents must survive a pipeline reset.
    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;
    logic [31:0] w_merged;

    always_comb begin
        w_merged = r_mem[i_addr];
        for (int b = 0; b < 4; b++) begin
            if (i_we && i_be[b]) w_merged[8*b +: 8] = i_wdata[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_we && i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
        r_rdata <= w_merged;
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_stage.sv
// Load/store pipeline stage: stage 1 accesses the RAM and checks legality,
// stage 2 lane-selects, extends and registers the writeback.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int RAM_DEPTH = cRamDepth
) (
    input  logic  clk,
    input  logic  rst,
    input  tMemOp iMemOp,
    input  tRegOp iRegOp,
    output tRegOp oRegOp,
    output logic  oMemErr
);

    localparam int cAw = $clog2(RAM_DEPTH);

    logic [1:0]       w_lane;
    logic             w_ld_ok;
    logic             w_st_ok;
    logic             w_we;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;
    logic [31:0]      w_rdata;
    tMemPipe          w_pipe_nxt;
    tMemPipe          r_pipe;
    logic [31:0]      w_shift;
    logic [31:0]      w_ext;
    tRegOp            w_out;
    tRegOp            r_out;
    logic             r_err;

    assign w_lane  = iMemOp.addr[1:0];
    assign w_ld_ok = ld_legal(iMemOp.opType, w_lane);
    assign w_st_ok = st_legal(iMemOp.opType, w_lane);
    assign w_we    = iMemOp.write && w_st_ok && !rst;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = iMemOp.data;
        case (iMemOp.opType)
            cSb: begin
                w_be    = 4'b0001 << w_lane;
                w_wdata = {4{iMemOp.data[7:0]}};
            end
            cSh: begin
                w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{iMemOp.data[15:0]}};
            end
            cSw:     w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    data_ram #(
        .DEPTH (RAM_DEPTH),
        .AW    (cAw)
    ) u_data_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_be    (w_be),
        .i_addr  (iMemOp.addr[cAw+1:2]),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    // A read never combines with a write or a live ALU result without an error.
    always_comb begin
        w_pipe_nxt        = '0;
        w_pipe_nxt.mem    = iMemOp.read || iMemOp.write;
        w_pipe_nxt.ld     = iMemOp.read && !iMemOp.write && w_ld_ok && (iMemOp.rdAddr != 5'd0);
        w_pipe_nxt.err    = (iMemOp.read && iMemOp.write)
                          || (iMemOp.read && iRegOp.dv)
                          || (iMemOp.read && !w_ld_ok)
                          || (iMemOp.write && !w_st_ok);
        w_pipe_nxt.op     = iMemOp.opType;
        w_pipe_nxt.lane   = w_lane;
        w_pipe_nxt.rd     = iMemOp.rdAddr;
        w_pipe_nxt.reg_op = iRegOp;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) r_pipe <= '0;
        else     r_pipe <= w_pipe_nxt;
    end

    assign w_shift = w_rdata >> {r_pipe.lane, 3'b000};

    always_comb begin
        w_ext = w_rdata;
        case (r_pipe.op)
            cLb:     w_ext = {{24{w_shift[7]}}, w_shift[7:0]};
            cLbu:    w_ext = {24'd0, w_shift[7:0]};
            cLh:     w_ext = {{16{w_shift[15]}}, w_shift[15:0]};
            cLhu:    w_ext = {16'd0, w_shift[15:0]};
            default: w_ext = w_rdata;
        endcase
    end

    always_comb begin
        w_out = r_pipe.reg_op;
        if (r_pipe.mem) w_out = cRegOp;
        if (r_pipe.ld)  w_out = '{dv: 1'b1, addr: r_pipe.rd, data: w_ext};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= cRegOp;
            r_err <= 1'b0;
        end else begin
            r_out <= w_out;
            r_err <= r_pipe.err;
        end
    end

    assign oRegOp  = r_out;
    assign oMemErr = r_err;

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter RAM_DEPTH, default cRamDepth (1024), data RAM depth in 32-bit words.
REQ-002 clk  in  1  rising-edge clock, sole clock domain.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 iMemOp  in  tMemOp  load/store request from ALU stage (read, write, addr, data, opType = funct3, rdAddr).
REQ-005 iRegOp  in  tRegOp  ALU register result, passed through to writeback.
REQ-006 oRegOp  out  tRegOp  writeback to register file (dv, addr, data).
REQ-007 oMemErr  out  1  one-cycle pulse on a rejected memory request.

Function
REQ-008 Fixed two-stage pipeline, no stalls: a request sampled in cycle N produces oRegOp/oMemErr in cycle N+2; one request accepted per cycle; order preserved.
REQ-009 Stage 1: RAM access, capture of opType, addr[1:0], rdAddr and passthrough iRegOp; stage 2: byte/half lane select, extension, output register.
REQ-010 Word index = addr[log2(RAM_DEPTH)+1:2]; upper address bits ignored (wrap-around, no error).
REQ-011 Loads: opType 000 LB sign-ext, 001 LH sign-ext, 010 LW, 100 LBU zero-ext, 101 LHU zero-ext; lane selected by addr[1:0] (little-endian).
REQ-012 Stores: opType 000 SB writes byte lane addr[1:0] from data[7:0]; 001 SH writes half lane addr[1] from data[15:0]; 010 SW writes all four bytes; other lanes unchanged.
REQ-013 Misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0): access suppressed, no RAM write, no writeback, oMemErr=1 at N+2.
REQ-014 Undefined opType for read (011,110,111) or write (011..111): same handling as REQ-013.
REQ-015 read and write both 1: write performed if legal, read dropped, oMemErr=1 at N+2.
REQ-016 Valid load: oRegOp = {dv=1, addr=rdAddr, data=extended value} at N+2; rdAddr=0 gives dv=0.
REQ-017 Store: oRegOp.dv=0 at N+2.
REQ-018 No memory op: oRegOp = iRegOp delayed 2 cycles unchanged.
REQ-019 read=1 together with iRegOp.dv=1: load result wins, iRegOp discarded, oMemErr=1.
REQ-020 Read-after-write: a load in cycle N+1 to the word stored in cycle N returns the merged new data (write-first RAM or bypass); same-cycle hazards impossible per REQ-015.
REQ-021 oMemErr is never asserted for a cycle with no request.

Reset
REQ-022 While rst=1: both pipeline stages cleared, oRegOp=cRegOp, oMemErr=0, RAM writes blocked.
REQ-023 Requests in flight when rst asserts are discarded, no writeback at any later cycle; RAM contents not cleared.
REQ-024 First request accepted in the cycle after rst deasserts.

Structure
REQ-025 corePckg gains: load/store opType constants (cLb, cLh, cLw, cLbu, cLhu, cSb, cSh, cSw) and a tMemPipe struct for stage-1 state.
REQ-026 tMemOp, tRegOp, cRegOp, cXLEN, cRamDepth reused from corePckg unchanged.
REQ-027 Sub-module data_ram: single-port synchronous RAM, 32-bit, 4 byte-enables, 1-cycle read latency, write-first.
REQ-028 RTL size 120-400 lines including data_ram.

Verification
REQ-029 SW addr 0x10 data 0xDEADBEEF, then LW 0x10 rd=5 -> oRegOp {1,5,0xDEADBEEF} two cycles after LW.
REQ-030 After REQ-029: LB 0x13 rd=6 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
REQ-031 SB 0x11 data 0x55 in cycle N, LW 0x10 rd=7 in N+1 -> 0xDEAD55EF at N+3 (back-to-back bypass).
REQ-032 LW 0x12 and SH 0x11 -> oMemErr pulse each, oRegOp.dv=0, RAM word unchanged.
REQ-033 iRegOp {1,3,0x1234} with no mem op -> identical oRegOp two cycles later; LW rd=0 -> dv=0.
REQ-034 LW issued, rst asserted next cycle -> no oRegOp.dv and no oMemErr ever for that LW; RAM data retained after reset.
